// File: rtl/grid_io_bank.sv
// grid_io_bank: multi-channel GPIO perimeter tile. A single configuration
// chain segment holds four bits per pad channel (OE, IE, INV, REG). A bit
// counter reports a complete load and flags an over-long bitstream. While the
// chain is shifting, pad enables and fabric inputs are held safe.
module grid_io_bank #(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  output logic              ccff_done,
  output logic              ccff_err,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_A,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_OE,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_IE,
  input  logic [NUM_IO-1:0] gfpga_pad_GPIO_Y
);

  localparam int TOTAL = NUM_IO * 4;
  localparam int CW = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] FULL = CW'(TOTAL);

  // cfg[0] is the head end of the chain; cfg[TOTAL-1] feeds ccff_tail.
  logic [TOTAL-1:0]  cfg;
  logic [NUM_IO-1:0] y_p1;
  logic [CW-1:0]     cnt;
  logic              err;
  logic              en;

  // Configuration shift register; reset discards any partial bitstream.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cfg <= '0;
    end else if (ccff_en) begin
      cfg <= {cfg[TOTAL-2:0], ccff_head};
    end
  end

  // Pad receive data captured every cycle for the registered input option.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      y_p1 <= '0;
    end else begin
      y_p1 <= gfpga_pad_GPIO_Y;
    end
  end

  // Saturating bit counter and sticky over-length flag; the shift itself is never blocked.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (ccff_en) begin
      if (cnt < FULL) begin
        cnt <= cnt + CW'(1);
      end else begin
        err <= 1'b1;
      end
    end
  end

  assign ccff_tail = cfg[TOTAL-1];
  assign ccff_done = (cnt == FULL);
  assign ccff_err  = err;

  // Outputs only become live once shifting stops; no extra cycle is added.
  assign en = ~ccff_en;

  genvar k;
  generate
    for (k = 0; k < NUM_IO; k++) begin : g_ch
      logic oe_c, ie_c, inv_c, reg_c;
      assign oe_c  = cfg[4*k+0];
      assign ie_c  = cfg[4*k+1];
      assign inv_c = cfg[4*k+2];
      assign reg_c = cfg[4*k+3];

      assign gfpga_pad_GPIO_OE[k] = oe_c & en;
      assign gfpga_pad_GPIO_IE[k] = ie_c & en;
      // Drive data is not gated by ccff_en: OE already keeps the pad off.
      assign gfpga_pad_GPIO_A[k]  = oe_c ? (io_outpad[k] ^ inv_c) : 1'b0;
      assign io_inpad[k]          = (ie_c & en) ?
                                    (reg_c ? y_p1[k] : gfpga_pad_GPIO_Y[k]) : 1'b0;
    end
  endgenerate

endmodule

// File: doc/grid_io_bank.md
# grid_io_bank

Parametrised multi-channel I/O tile and the successor to the single-pad grid I/O tile. It serves `NUM_IO` GPIO pads from one configuration-chain segment. Per-channel configuration sets output enable, input enable, output inversion and an optional registered input path. The block counts configuration bits so it can report when its segment is fully loaded and flag a bitstream that is too long. It sits on the fabric perimeter, between routing channels and the pad ring, in series with the `ccff_head`/`ccff_tail` chain.

## Interface
Parameters:
- `NUM_IO`, default 4: number of pad channels, 1..32.
- `TOTAL` (localparam) = `NUM_IO*4`: configuration bits held.
- `CW` (localparam) = `$clog2(TOTAL+1)`: bit-counter width.

Ports:
- `prog_clk`, input, 1: the only clock. All state updates on its rising edge.
- `pReset`, input, 1: reset. Synchronous, active-high.
- `ccff_en`, input, 1: chain shift enable.
- `ccff_head`, input, 1: serial configuration data in.
- `ccff_tail`, output, 1: serial configuration data out. Equals the last chain bit.
- `ccff_done`, output, 1: high when exactly `TOTAL` bits have been shifted since reset.
- `ccff_err`, output, 1: sticky flag for over-length shifting.
- `io_outpad`, input, `NUM_IO`: fabric-to-pad data.
- `io_inpad`, output, `NUM_IO`: pad-to-fabric data.
- `gfpga_pad_GPIO_A`, output, `NUM_IO`: pad drive data.
- `gfpga_pad_GPIO_OE`, output, `NUM_IO`: pad output enable.
- `gfpga_pad_GPIO_IE`, output, `NUM_IO`: pad input enable.
- `gfpga_pad_GPIO_Y`, input, `NUM_IO`: pad receive data.

## Operation
- **Chain.** Register `cfg[0:TOTAL-1]`.
  - When `ccff_en`=1: `cfg[0]<=ccff_head` and `cfg[i]<=cfg[i-1]`.
  - Otherwise `cfg` holds its value.
  - `ccff_tail = cfg[TOTAL-1]`.
- **Channel k field** is `cfg[4k+0..4k+3]`:
  - `OE = cfg[4k]`
  - `IE = cfg[4k+1]`
  - `INV = cfg[4k+2]`
  - `REG = cfg[4k+3]`
- **Safe gating while shifting.** While `ccff_en`=1, every channel's `GPIO_OE` and `GPIO_IE` are forced to 0 and `io_inpad` is forced to 0.
- **Channel outputs, all combinational.** Let `en = ~ccff_en`.
  - `GPIO_OE[k] = OE & en`
  - `GPIO_IE[k] = IE & en`
  - `GPIO_A[k] = OE ? (io_outpad[k] ^ INV) : 0`
  - `io_inpad[k] = (IE & en) ? (REG ? y_q[k] : GPIO_Y[k]) : 0`
- **Input register.** `y_q[k] <= GPIO_Y[k]` every cycle, independent of configuration.
- **Bit counter** `cnt[CW-1:0]`:
  - Increments on each shift while `cnt<TOTAL`, and saturates at `TOTAL`.
  - `ccff_done = (cnt==TOTAL)`.
- **Error flag.** A shift with `cnt==TOTAL` sets `ccff_err`. It stays set until reset and does not block the shift itself.
- **Reset** (`pReset`=1 at a clock edge):
  - `cfg`, `y_q`, `cnt` and `ccff_err` are cleared.
  - Reset overrides `ccff_en` in the same cycle; no shift occurs.
- **Outputs after reset:**
  - `ccff_tail`=0, `ccff_done`=0, `ccff_err`=0.
  - `GPIO_OE`, `GPIO_IE` and `GPIO_A` are all 0.
  - `io_inpad` is all 0.
- **Reset mid-load.** A partial bitstream is discarded and the count restarts from 0.

## Timing
- Shift latency: the bit presented on `ccff_head` in shift cycle n appears on `ccff_tail` after `TOTAL` shift cycles.
  - Cycles with `ccff_en`=0 do not advance the chain.
- `ccff_done` rises in the cycle after the `TOTAL`-th shift edge.
- `ccff_err` rises after the edge of shift number `TOTAL+1`.
- Configuration takes effect combinationally once `ccff_en` falls. There is no extra cycle.
- Registered input path: exactly 1 `prog_clk` cycle of latency.
- Unregistered input path and all output paths: 0 cycles of latency.
- Simultaneous `ccff_en`=1 and `pReset`=1: reset wins.
- No combinational path from `ccff_head` to `ccff_tail`.

## Test plan
1. **Reset values.** Assert `pReset` for 2 cycles with `ccff_en`=1 and `ccff_head`=1.
   - All outputs 0 and `cnt`=0.
2. **Full load, `NUM_IO`=4.** Shift 16 bits such that, after loading, channel 0 = `OE=1,IE=0,INV=1,REG=0` and channel 1 = `OE=0,IE=1,INV=0,REG=1`; other channels 0. Then drop `ccff_en`.
   - `ccff_done`=1 after the 16th edge.
   - `io_outpad[0]`=1 gives `GPIO_A[0]`=0 and `GPIO_OE[0]`=1.
   - A `GPIO_Y[1]` step appears on `io_inpad[1]` one cycle later.
3. **Chain pass-through.** Shift pattern `1,0,0,...` with 16 shifts then 1 more.
   - The 1 is visible on `ccff_tail` exactly after the 16th shift.
   - `ccff_err`=1 after the 17th shift.
4. **Gating during reload.** After the load in scenario 2, raise `ccff_en`.
   - `GPIO_OE`, `GPIO_IE` and `io_inpad` all go to 0 in the same cycle.
   - `GPIO_A[0]` follows the shifting `cfg`.
5. **Reset mid-load.** Shift 7 bits, pulse `pReset`, then shift 16 bits.
   - `ccff_done` is 0 throughout the first phase and rises only after the 16th post-reset shift.
   - `ccff_err` stays 0.
6. **Hold cycles.** Interleave `ccff_en`=0 gaps during loading.
   - Final `cfg` and `cnt` are identical to a gap-free load.
